// File: rtl/rv32_mem_pkg.sv
// Shared RV32I load/store definitions: funct3 codes, access-controller state
// encoding and the legality check used when an access enters the controller.
package rv32_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_WAIT_RD = 2'd2,
        ST_DONE    = 2'd3
    } mem_state_t;

    // Size is encoded in funct3[1:0] for both loads and stores (01 half, 10 word),
    // so one misalignment rule covers LH/LHU/SH and LW/SW.
    function automatic logic access_bad(input logic       we,
                                        input logic [2:0] funct3,
                                        input logic [1:0] off);
        logic illegal;
        logic misal;
        if (we) begin
            illegal = (funct3 > F3_SW);
        end else begin
            illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
        end
        misal = ((funct3[1:0] == 2'b01) && off[0]) ||
                ((funct3[1:0] == 2'b10) && (off != 2'b00));
        return illegal || misal;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: shifts the addressed lane down to bit 0 and applies
// sign/zero extension according to funct3. Purely combinational.
module mem_load_align
    import rv32_mem_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [31:0] w_shift;

    always_comb begin
        w_shift = i_rdata >> {i_off, 3'b000};
        case (i_funct3)
            F3_LB:   o_data = {{24{w_shift[7]}}, w_shift[7:0]};
            F3_LH:   o_data = {{16{w_shift[15]}}, w_shift[15:0]};
            F3_LBU:  o_data = {24'd0, w_shift[7:0]};
            F3_LHU:  o_data = {16'd0, w_shift[15:0]};
            default: o_data = w_shift;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access controller: sequences one load/store at a time
// onto a req/gnt + rvalid port, stalling the pipeline until it completes.
module dmem_access_ctrl
    import rv32_mem_pkg::*;
#(
    parameter int TIMEOUT = 255
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_we,
    input  logic [2:0]  mem_funct3,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        stall_out,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        misalign_err,
    output logic        bus_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_mask,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic [1:0]  dbg_state
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    mem_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_we;
    logic [2:0]    r_funct3;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [3:0]    r_mask;
    logic          r_req;
    logic [31:0]   r_load_data;
    logic          r_load_valid;
    logic          r_bus_err;

    logic          w_bad;
    logic          w_accept;
    logic          w_timeout;
    logic [3:0]    w_mask;
    logic [31:0]   w_wdata;
    logic [31:0]   w_aligned;

    assign w_bad     = access_bad(mem_we, mem_funct3, mem_addr[1:0]);
    assign w_accept  = (r_state == ST_IDLE) && mem_valid && !w_bad;
    assign w_timeout = (r_cnt == CNT_LAST);

    // Store lanes: replicate the narrow datum across the word, the mask picks the lane.
    always_comb begin
        w_mask  = 4'b0000;
        w_wdata = mem_wdata;
        if (mem_we) begin
            case (mem_funct3)
                F3_SB: begin
                    w_mask  = 4'b0001 << mem_addr[1:0];
                    w_wdata = {4{mem_wdata[7:0]}};
                end
                F3_SH: begin
                    w_mask  = 4'b0011 << mem_addr[1:0];
                    w_wdata = {2{mem_wdata[15:0]}};
                end
                default: begin
                    w_mask  = 4'b1111;
                    w_wdata = mem_wdata;
                end
            endcase
        end
    end

    mem_load_align u_load_align (
        .i_rdata  (dmem_rdata),
        .i_off    (r_addr[1:0]),
        .i_funct3 (r_funct3),
        .o_data   (w_aligned)
    );

    // Handshake: dmem_req rises with we/addr/wdata/mask already stable and stays
    // high (payload unchanged) until the first cycle dmem_gnt is seen high; read
    // data is taken on dmem_rvalid only in that gnt cycle or in WAIT_RD. gnt and
    // rvalid seen in any other state are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_we         <= 1'b0;
            r_funct3     <= 3'd0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_mask       <= 4'd0;
            r_req        <= 1'b0;
            r_load_data  <= 32'd0;
            r_load_valid <= 1'b0;
            r_bus_err    <= 1'b0;
        end else begin
            r_load_valid <= 1'b0;
            r_bus_err    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_accept) begin
                        r_we     <= mem_we;
                        r_funct3 <= mem_funct3;
                        r_addr   <= mem_addr;
                        r_wdata  <= w_wdata;
                        r_mask   <= w_mask;
                        r_req    <= 1'b1;
                        r_state  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (dmem_gnt && (r_we || dmem_rvalid)) begin
                        r_req <= 1'b0;
                        if (!r_we) begin
                            r_load_data  <= w_aligned;
                            r_load_valid <= 1'b1;
                        end
                        r_state <= ST_DONE;
                    end else if (w_timeout) begin
                        r_req     <= 1'b0;
                        r_bus_err <= 1'b1;
                        r_load_data  <= 32'd0;
                        r_load_valid <= 1'b1;
                        r_state   <= ST_DONE;
                    end else if (dmem_gnt) begin
                        r_req   <= 1'b0;
                        r_state <= ST_WAIT_RD;
                    end
                end
                ST_WAIT_RD: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (dmem_rvalid) begin
                        r_load_data  <= w_aligned;
                        r_load_valid <= 1'b1;
                        r_state      <= ST_DONE;
                    end else if (w_timeout) begin
                        r_bus_err    <= 1'b1;
                        r_load_data  <= 32'd0;
                        r_load_valid <= 1'b1;
                        r_state      <= ST_DONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
            // A timed-out store leaves the last load result untouched.
            if ((r_state == ST_REQ) && r_we && !dmem_gnt && w_timeout) begin
                r_load_data  <= r_load_data;
                r_load_valid <= 1'b0;
            end
        end
    end

    // Stall is combinational in IDLE so the access holds the pipeline the cycle it appears.
    always_comb begin
        case (r_state)
            ST_IDLE:    stall_out = mem_valid && !w_bad;
            ST_REQ:     stall_out = 1'b1;
            ST_WAIT_RD: stall_out = 1'b1;
            default:    stall_out = 1'b0;
        endcase
    end

    assign misalign_err = (r_state == ST_IDLE) && mem_valid && w_bad;
    assign load_data    = r_load_data;
    assign load_valid   = r_load_valid;
    assign bus_err      = r_bus_err;
    assign dmem_req     = r_req;
    assign dmem_we      = r_we;
    assign dmem_addr    = {r_addr[31:2], 2'b00};
    assign dmem_wdata   = r_wdata;
    assign dmem_mask    = r_mask;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed cases plus a random
// load/store stream checked against a reference memory model.
module tb_dmem_access_ctrl;
    import rv32_mem_pkg::*;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_we;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_addr, mem_wdata;
    logic        stall_out, load_valid, misalign_err, bus_err;
    logic [31:0] load_data;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_mask;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [1:0]  dbg_state;

    dmem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_funct3(mem_funct3),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .stall_out(stall_out), .load_data(load_data), .load_valid(load_valid),
        .misalign_err(misalign_err), .bus_err(bus_err),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_mask(dmem_mask),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] bus_mem [0:255];
    logic [31:0] ref_mem [0:255];

    int          res_stalls, res_reqs;
    logic        res_misal, res_berr, res_lv;
    logic [3:0]  res_mask;
    logic [31:0] res_wdata, res_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*off +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'd0:    return {{24{b[7]}}, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd4:    return {24'd0, b};
            3'd5:    return {16'd0, h};
            default: return w;
        endcase
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        logic [7:0] idx;
        idx = addr[9:2];
        case (f3)
            3'd0:    ref_mem[idx][8*addr[1:0] +: 8] = wd[7:0];
            3'd1:    ref_mem[idx][16*addr[1] +: 16] = wd[15:0];
            default: ref_mem[idx] = wd;
        endcase
    endtask

    // Scoreboard: every load_valid pops the oldest expected load result.
    always @(negedge clk) begin
        if (!rst && load_valid) begin
            if (exp_q.size() == 0) check("unexpected_load_valid", {31'd0, load_valid}, 32'd0);
            else check("load_data", load_data, exp_q.pop_front());
        end
    end

    // Presents one access and acts as the memory; returns at posedge+1 after completion.
    task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input int gnt_dly, input int rv_dly);
        int cyc;
        int gnt_at;
        bit gnt_ld;
        bit done;
        cyc = 0; gnt_at = -1; gnt_ld = 0; done = 0;
        res_stalls = 0; res_reqs = 0; res_misal = 0; res_berr = 0; res_lv = 0;
        res_mask = 4'd0; res_wdata = 32'd0; res_addr = 32'd0;
        mem_valid = 1'b1; mem_we = we; mem_funct3 = f3; mem_addr = addr; mem_wdata = wd;
        while (!done) begin
            @(negedge clk);
            dmem_gnt = 1'b0;
            dmem_rvalid = 1'b0;
            if (stall_out) res_stalls++;
            if (dmem_req) begin
                if (res_reqs == gnt_dly) begin
                    dmem_gnt  = 1'b1;
                    res_mask  = dmem_mask;
                    res_wdata = dmem_wdata;
                    res_addr  = dmem_addr;
                    gnt_at    = cyc;
                    gnt_ld    = !dmem_we;
                    if (dmem_we) begin
                        for (int i = 0; i < 4; i++)
                            if (dmem_mask[i]) bus_mem[dmem_addr[9:2]][8*i +: 8] = dmem_wdata[8*i +: 8];
                    end else if (rv_dly == 0) begin
                        dmem_rvalid = 1'b1;
                        dmem_rdata  = bus_mem[dmem_addr[9:2]];
                    end
                end
                res_reqs++;
            end else if (gnt_ld && rv_dly > 0 && cyc == gnt_at + rv_dly) begin
                dmem_rvalid = 1'b1;
                dmem_rdata  = bus_mem[res_addr[9:2]];
            end
            res_misal = res_misal | misalign_err;
            res_berr  = res_berr | bus_err;
            res_lv    = res_lv | load_valid;
            if (!stall_out) done = 1;
            cyc++;
            if (cyc > 200) begin
                check("access_cycle_budget", cyc, 32'd200);
                done = 1;
            end
        end
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b0;
    endtask

    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input int gnt_dly, input int rv_dly);
        if (we) ref_store(f3, addr, wd);
        else exp_q.push_back(ref_load(f3, addr[1:0], ref_mem[addr[9:2]]));
        do_access(we, f3, addr, wd, gnt_dly, rv_dly);
    endtask

    initial begin
        logic [2:0] ld_f3 [5];
        logic       lv_seen;
        ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int i = 0; i < 256; i++) begin
            bus_mem[i] = $urandom;
            ref_mem[i] = bus_mem[i];
        end
        rst = 1'b1; mem_valid = 1'b0; mem_we = 1'b0; mem_funct3 = 3'd0;
        mem_addr = 32'd0; mem_wdata = 32'd0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        check("rst_stall", {31'd0, stall_out}, 32'd0);
        check("rst_load_data", load_data, 32'd0);
        check("rst_req", {31'd0, dmem_req}, 32'd0);
        check("rst_mask", {28'd0, dmem_mask}, 32'd0);
        @(posedge clk);
        #1;

        // SW, gnt in first REQ cycle
        do_access(1'b1, F3_SW, 32'h100, 32'hDEADBEEF, 0, 0);
        ref_store(F3_SW, 32'h100, 32'hDEADBEEF);
        check("sw_mask", {28'd0, res_mask}, 32'h0000000F);
        check("sw_addr", res_addr, 32'h100);
        check("sw_wdata", res_wdata, 32'hDEADBEEF);
        check("sw_stall", res_stalls, 32'd2);
        check("sw_no_lv", {31'd0, res_lv}, 32'd0);

        // SB lane 3
        do_access(1'b1, F3_SB, 32'h103, 32'h000000A5, 1, 0);
        ref_store(F3_SB, 32'h103, 32'h000000A5);
        check("sb_mask", {28'd0, res_mask}, 32'h00000008);
        check("sb_wdata", res_wdata, 32'hA5A5A5A5);
        check("sb_mem", bus_mem[8'h40], 32'hA5ADBEEF);

        // LB / LBU with rvalid two cycles after gnt
        bus_mem[8'h40] = 32'h1280FF00;
        ref_mem[8'h40] = 32'h1280FF00;
        exp_q.push_back(32'hFFFFFF80);
        do_access(1'b0, F3_LB, 32'h102, 32'd0, 0, 2);
        check("lb_stall", res_stalls, 32'd4);
        check("lb_lv", {31'd0, res_lv}, 32'd1);
        exp_q.push_back(32'h00000080);
        do_access(1'b0, F3_LBU, 32'h102, 32'd0, 0, 2);
        check("lbu_lv", {31'd0, res_lv}, 32'd1);
        check("lbu_load_data_hold", load_data, 32'h00000080);

        // Misaligned / illegal: no request, no stall
        do_access(1'b0, F3_LH, 32'h101, 32'd0, 0, 0);
        check("lh_mis_err", {31'd0, res_misal}, 32'd1);
        check("lh_mis_req", res_reqs, 32'd0);
        check("lh_mis_stall", res_stalls, 32'd0);
        do_access(1'b0, F3_LW, 32'h102, 32'd0, 0, 0);
        check("lw_mis_err", {31'd0, res_misal}, 32'd1);
        check("lw_mis_req", res_reqs, 32'd0);
        do_access(1'b0, 3'd3, 32'h100, 32'd0, 0, 0);
        check("ld_f3_3_err", {31'd0, res_misal}, 32'd1);
        check("ld_f3_3_stall", res_stalls, 32'd0);
        do_access(1'b1, 3'd3, 32'h100, 32'd0, 0, 0);
        check("st_f3_3_err", {31'd0, res_misal}, 32'd1);
        check("st_f3_3_req", res_reqs, 32'd0);
        check("lbu_data_kept", load_data, 32'h00000080);

        // Timeout with gnt withheld
        exp_q.push_back(32'd0);
        do_access(1'b0, F3_LW, 32'h010, 32'd0, 1000, 0);
        check("to_bus_err", {31'd0, res_berr}, 32'd1);
        check("to_req_cycles", res_reqs, TO);
        check("to_stall", res_stalls, TO + 1);
        check("to_lv", {31'd0, res_lv}, 32'd1);
        check("to_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        run_op(1'b0, F3_LW, 32'h020, 32'd0, 2, 1);
        check("post_to_no_berr", {31'd0, res_berr}, 32'd0);

        // Reset in WAIT_RD, stale rvalid after release
        mem_valid = 1'b1; mem_we = 1'b0; mem_funct3 = F3_LW; mem_addr = 32'h44;
        lv_seen = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rstmid_req", {31'd0, dmem_req}, 32'd1);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        @(negedge clk);
        check("rstmid_wait", {30'd0, dbg_state}, {30'd0, ST_WAIT_RD});
        @(posedge clk);
        #1 rst = 1'b1; mem_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        lv_seen = lv_seen | load_valid;
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        lv_seen = lv_seen | load_valid;
        check("rstmid_no_lv", {31'd0, lv_seen}, 32'd0);
        check("rstmid_load_data", load_data, 32'd0);
        check("rstmid_stall", {31'd0, stall_out}, 32'd0);
        check("rstmid_req_low", {31'd0, dmem_req}, 32'd0);
        check("rstmid_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        @(posedge clk);
        #1;
        run_op(1'b0, F3_LW, 32'h44, 32'd0, 1, 2);

        // Random back-to-back stream against the reference memory
        for (int n = 0; n < 30; n++) begin
            logic        we;
            logic [2:0]  f3;
            logic [31:0] addr;
            logic [1:0]  off;
            we = ($urandom_range(0, 1) == 1);
            if (we) f3 = 3'($urandom_range(0, 2));
            else    f3 = ld_f3[$urandom_range(0, 4)];
            case (f3[1:0])
                2'b00:   off = 2'($urandom_range(0, 3));
                2'b01:   off = {1'($urandom_range(0, 1)), 1'b0};
                default: off = 2'b00;
            endcase
            addr = {22'd0, 8'($urandom_range(0, 15)), off};
            run_op(we, f3, addr, $urandom, $urandom_range(0, 4), $urandom_range(0, 3));
            check("stream_no_berr", {31'd0, res_berr}, 32'd0);
        end

        repeat (2) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
